// File: rtl/dcache_victim_buffer.sv
// Victim buffer between the dcache and memory: queues dirty evicted lines, merges
// re-evictions of a queued line, drains them as BUS_STORE and answers load-miss probes.
`ifndef DATA_SIZE
`define DATA_SIZE 64
`endif
`ifndef NUM_MEM_TAGS
`define NUM_MEM_TAGS 15
`endif

package dcache_victim_buffer_pkg;
    typedef enum logic [1:0] {
        BUS_NONE    = 2'h0,
        BUS_LOAD    = 2'h1,
        BUS_STORE   = 2'h2,
        BUS_INVALID = 2'h3
    } BUS_COMMAND;

    typedef enum logic [1:0] {
        VB_IDLE  = 2'h0,
        VB_ISSUE = 2'h1,
        VB_HOLD  = 2'h2
    } vb_state_e;
endpackage

module dcache_victim_buffer
    import dcache_victim_buffer_pkg::*;
#(
    parameter int VB_DEPTH  = 4,
    parameter int DATA_SIZE = `DATA_SIZE
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic                              evict_en,
    input  logic [31:0]                       evict_addr,
    input  logic [DATA_SIZE-1:0]              evict_data,
    input  logic                              bus_busy,
    input  logic [$clog2(`NUM_MEM_TAGS)-1:0]  mem2proc_response,
    input  logic                              lookup_en,
    input  logic [31:0]                       lookup_addr,
    output BUS_COMMAND                        proc2mem_command,
    output logic [31:0]                       proc2mem_addr,
    output logic [DATA_SIZE-1:0]              proc2mem_data,
    output logic                              full,
    output logic                              empty,
    output logic [$clog2(VB_DEPTH):0]         count,
    output logic                              lookup_hit,
    output logic [DATA_SIZE-1:0]              lookup_data,
    output logic                              overflow,
    output logic [1:0]                        state_dbg
);

    localparam int PW = $clog2(VB_DEPTH);
    localparam logic [PW:0] DEPTH_CNT = VB_DEPTH[PW:0];

    vb_state_e            state_q, state_d;
    logic [PW-1:0]        head_q, head_d;
    logic [PW-1:0]        tail_q, tail_d;
    logic [PW:0]          count_q, count_d;
    logic                 overflow_q, overflow_d;
    logic                 valid_q [VB_DEPTH];
    logic                 valid_d [VB_DEPTH];
    logic [28:0]          tag_q   [VB_DEPTH];
    logic [28:0]          tag_d   [VB_DEPTH];
    logic [DATA_SIZE-1:0] data_q  [VB_DEPTH];
    logic [DATA_SIZE-1:0] data_d  [VB_DEPTH];

    logic                 store_out;
    logic                 pop;
    logic                 coal_hit;
    logic [PW-1:0]        coal_idx;
    logic                 alloc;
    logic                 drop;
    logic                 full_w;
    logic [5:0]           unused_addr_bits;

    assign unused_addr_bits = {evict_addr[2:0], lookup_addr[2:0]};

    // Bus handshake: a store is offered while proc2mem_command is BUS_STORE and is
    // taken in the same cycle iff mem2proc_response != 0; otherwise it is re-offered unchanged.
    assign store_out = (state_q == VB_ISSUE) && !bus_busy;
    assign pop       = store_out && (mem2proc_response != '0);
    assign full_w    = (count_q == DEPTH_CNT);

    always_comb begin
        coal_hit = 1'b0;
        coal_idx = '0;
        for (int i = 0; i < VB_DEPTH; i++) begin
            if (valid_q[i] && (tag_q[i] == evict_addr[31:3]) &&
                !(pop && (PW'(i) == head_q))) begin
                coal_hit = 1'b1;
                coal_idx = PW'(i);
            end
        end
    end

    // A full buffer refuses new lines even if the head leaves in the same cycle.
    assign alloc = evict_en && !coal_hit && !full_w;
    assign drop  = evict_en && !coal_hit && full_w;

    always_comb begin
        head_d     = head_q;
        tail_d     = tail_q;
        overflow_d = overflow_q | drop;
        count_d    = count_q + {{PW{1'b0}}, alloc} - {{PW{1'b0}}, pop};
        for (int i = 0; i < VB_DEPTH; i++) begin
            valid_d[i] = valid_q[i];
            tag_d[i]   = tag_q[i];
            data_d[i]  = data_q[i];
        end
        if (pop) begin
            valid_d[head_q] = 1'b0;
            head_d          = head_q + PW'(1);
        end
        if (evict_en && coal_hit) begin
            data_d[coal_idx] = evict_data;
        end else if (alloc) begin
            valid_d[tail_q] = 1'b1;
            tag_d[tail_q]   = evict_addr[31:3];
            data_d[tail_q]  = evict_data;
            tail_d          = tail_q + PW'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= VB_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            VB_IDLE:  if (alloc) state_d = VB_ISSUE;
            VB_ISSUE: begin
                if (pop && (count_d == '0)) state_d = VB_IDLE;
                else if (bus_busy)          state_d = VB_HOLD;
            end
            VB_HOLD:  if (!bus_busy) state_d = VB_ISSUE;
            default:  state_d = VB_IDLE;
        endcase
    end

    always_comb begin
        proc2mem_command = BUS_NONE;
        proc2mem_addr    = '0;
        proc2mem_data    = '0;
        if (store_out) begin
            proc2mem_command = BUS_STORE;
            proc2mem_addr    = {tag_q[head_q], 3'b000};
            proc2mem_data    = data_q[head_q];
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            for (int i = 0; i < VB_DEPTH; i++) begin
                valid_q[i] <= 1'b0;
                tag_q[i]   <= '0;
                data_q[i]  <= '0;
            end
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            for (int i = 0; i < VB_DEPTH; i++) begin
                valid_q[i] <= valid_d[i];
                tag_q[i]   <= tag_d[i];
                data_q[i]  <= data_d[i];
            end
        end
    end

    // Walk oldest to youngest so the youngest matching entry wins.
    always_comb begin
        logic [PW-1:0] idx;
        idx         = '0;
        lookup_hit  = 1'b0;
        lookup_data = '0;
        for (int i = 0; i < VB_DEPTH; i++) begin
            idx = head_q + PW'(i);
            if (lookup_en && ((PW+1)'(i) < count_q) && valid_q[idx] &&
                (tag_q[idx] == lookup_addr[31:3])) begin
                lookup_hit  = 1'b1;
                lookup_data = data_q[idx];
            end
        end
    end

    assign full      = full_w;
    assign empty     = (count_q == '0);
    assign count     = count_q;
    assign overflow  = overflow_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_dcache_victim_buffer.sv
// Directed bench for dcache_victim_buffer: hand-computed vectors for drain, coalesce,
// overflow, lookup, retry, pop+allocate and asynchronous reset mid-drain.
module tb_dcache_victim_buffer;

    localparam int DW = 64;
    localparam logic [1:0] CMD_NONE  = 2'h0;
    localparam logic [1:0] CMD_STORE = 2'h2;
    localparam logic [1:0] ST_IDLE   = 2'h0;
    localparam logic [1:0] ST_ISSUE  = 2'h1;
    localparam logic [1:0] ST_HOLD   = 2'h2;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          evict_en = 1'b0;
    logic [31:0]   evict_addr = '0;
    logic [DW-1:0] evict_data = '0;
    logic          bus_busy = 1'b0;
    logic [3:0]    mem2proc_response = '0;
    logic          lookup_en = 1'b0;
    logic [31:0]   lookup_addr = '0;
    logic [1:0]    proc2mem_command;
    logic [31:0]   proc2mem_addr;
    logic [DW-1:0] proc2mem_data;
    logic          full;
    logic          empty;
    logic [2:0]    count;
    logic          lookup_hit;
    logic [DW-1:0] lookup_data;
    logic          overflow;
    logic [1:0]    state_dbg;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0]   exp_addr_q[$];
    logic [DW-1:0] exp_data_q[$];

    dcache_victim_buffer #(.VB_DEPTH(4), .DATA_SIZE(DW)) dut (
        .clock             (clock),
        .reset             (reset),
        .evict_en          (evict_en),
        .evict_addr        (evict_addr),
        .evict_data        (evict_data),
        .bus_busy          (bus_busy),
        .mem2proc_response (mem2proc_response),
        .lookup_en         (lookup_en),
        .lookup_addr       (lookup_addr),
        .proc2mem_command  (proc2mem_command),
        .proc2mem_addr     (proc2mem_addr),
        .proc2mem_data     (proc2mem_data),
        .full              (full),
        .empty             (empty),
        .count             (count),
        .lookup_hit        (lookup_hit),
        .lookup_data       (lookup_data),
        .overflow          (overflow),
        .state_dbg         (state_dbg)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic evict(input logic [31:0] a, input logic [DW-1:0] d);
        evict_en   = 1'b1;
        evict_addr = a;
        evict_data = d;
    endtask

    task automatic expect_store(input logic [31:0] a, input logic [DW-1:0] d);
        exp_addr_q.push_back(a);
        exp_data_q.push_back(d);
    endtask

    // Releases the bus and compares every accepted store against the expected queue.
    task automatic drain(input logic [3:0] resp, input int max_cycles);
        logic [31:0]   ea;
        logic [DW-1:0] ed;
        bus_busy          = 1'b0;
        evict_en          = 1'b0;
        mem2proc_response = resp;
        for (int c = 0; c < max_cycles && exp_addr_q.size() > 0; c++) begin
            #1;
            if (proc2mem_command == CMD_STORE) begin
                ea = exp_addr_q.pop_front();
                ed = exp_data_q.pop_front();
                check_eq("drain_addr", 64'(proc2mem_addr), 64'(ea));
                check_eq("drain_data", proc2mem_data, ed);
            end
            tick();
        end
        if (exp_addr_q.size() != 0) begin
            check_eq("drain_timeout_left", 64'(exp_addr_q.size()), 64'd0);
            exp_addr_q.delete();
            exp_data_q.delete();
        end
        mem2proc_response = '0;
    endtask

    initial begin
        // Reset state
        lookup_en   = 1'b1;
        lookup_addr = 32'h1000;
        tick();
        tick();
        #1;
        check_eq("rst_cmd", 64'(proc2mem_command), 64'(CMD_NONE));
        check_eq("rst_empty", 64'(empty), 64'd1);
        check_eq("rst_full", 64'(full), 64'd0);
        check_eq("rst_count", 64'(count), 64'd0);
        check_eq("rst_overflow", 64'(overflow), 64'd0);
        check_eq("rst_state", 64'(state_dbg), 64'(ST_IDLE));
        check_eq("rst_hit", 64'(lookup_hit), 64'd0);
        reset     = 1'b0;
        lookup_en = 1'b0;
        tick();

        // Single eviction, stored the next cycle, aligned address
        evict(32'h1004, 64'hA5);
        tick();
        evict_en          = 1'b0;
        mem2proc_response = 4'd3;
        #1;
        check_eq("t1_cmd", 64'(proc2mem_command), 64'(CMD_STORE));
        check_eq("t1_addr", 64'(proc2mem_addr), 64'h1000);
        check_eq("t1_data", proc2mem_data, 64'hA5);
        check_eq("t1_state", 64'(state_dbg), 64'(ST_ISSUE));
        tick();
        mem2proc_response = '0;
        #1;
        check_eq("t1_cmd_after", 64'(proc2mem_command), 64'(CMD_NONE));
        check_eq("t1_empty", 64'(empty), 64'd1);
        check_eq("t1_state_idle", 64'(state_dbg), 64'(ST_IDLE));

        // Fill while the bus is busy, overflow, then in-order drain
        bus_busy = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            evict(32'(i * 32'h100), 64'(i));
            tick();
        end
        evict_en = 1'b0;
        #1;
        check_eq("t2_full", 64'(full), 64'd1);
        check_eq("t2_count", 64'(count), 64'd4);
        check_eq("t2_cmd_busy", 64'(proc2mem_command), 64'(CMD_NONE));
        check_eq("t2_state_hold", 64'(state_dbg), 64'(ST_HOLD));
        evict(32'h500, 64'h5);
        tick();
        evict_en = 1'b0;
        #1;
        check_eq("t2_overflow", 64'(overflow), 64'd1);
        check_eq("t2_count_kept", 64'(count), 64'd4);
        lookup_en   = 1'b1;
        lookup_addr = 32'h504;
        #1;
        check_eq("t2_dropped_miss", 64'(lookup_hit), 64'd0);
        lookup_en = 1'b0;
        for (int i = 1; i <= 4; i++) expect_store(32'(i * 32'h100), 64'(i));
        drain(4'd1, 20);
        #1;
        check_eq("t2_empty", 64'(empty), 64'd1);
        check_eq("t2_state_idle", 64'(state_dbg), 64'(ST_IDLE));
        check_eq("t2_overflow_sticky", 64'(overflow), 64'd1);

        // Coalesce into a queued line
        bus_busy = 1'b1;
        evict(32'h200, 64'h1);
        tick();
        evict(32'h204, 64'h2);
        tick();
        evict_en = 1'b0;
        #1;
        check_eq("t3_count", 64'(count), 64'd1);
        expect_store(32'h200, 64'h2);
        drain(4'd1, 20);
        #1;
        check_eq("t3_empty", 64'(empty), 64'd1);

        // Lookup hit/miss, lookup_en gating, same-cycle eviction invisible
        bus_busy = 1'b1;
        evict(32'h300, 64'h7);
        tick();
        evict(32'h600, 64'h8);
        tick();
        evict_en    = 1'b0;
        lookup_en   = 1'b1;
        lookup_addr = 32'h304;
        #1;
        check_eq("t4_hit", 64'(lookup_hit), 64'd1);
        check_eq("t4_hit_data", lookup_data, 64'h7);
        lookup_addr = 32'h700;
        #1;
        check_eq("t4_miss", 64'(lookup_hit), 64'd0);
        check_eq("t4_miss_data", lookup_data, 64'h0);
        lookup_en   = 1'b0;
        lookup_addr = 32'h304;
        #1;
        check_eq("t4_en_low", 64'(lookup_hit), 64'd0);
        evict(32'h900, 64'h9);
        lookup_en   = 1'b1;
        lookup_addr = 32'h900;
        #1;
        check_eq("t4_same_cycle_miss", 64'(lookup_hit), 64'd0);
        tick();
        evict_en = 1'b0;
        #1;
        check_eq("t4_next_cycle_hit", 64'(lookup_hit), 64'd1);
        check_eq("t4_next_cycle_data", lookup_data, 64'h9);
        lookup_en = 1'b0;
        expect_store(32'h300, 64'h7);
        expect_store(32'h600, 64'h8);
        expect_store(32'h900, 64'h9);
        drain(4'd1, 20);

        // Retry while memory refuses, single pop on acceptance
        bus_busy = 1'b0;
        evict(32'hA00, 64'h55);
        tick();
        evict_en          = 1'b0;
        mem2proc_response = '0;
        for (int k = 0; k < 3; k++) begin
            #1;
            check_eq("t5_retry_cmd", 64'(proc2mem_command), 64'(CMD_STORE));
            check_eq("t5_retry_addr", 64'(proc2mem_addr), 64'hA00);
            check_eq("t5_retry_count", 64'(count), 64'd1);
            tick();
        end
        mem2proc_response = 4'd2;
        #1;
        check_eq("t5_accept_data", proc2mem_data, 64'h55);
        tick();
        mem2proc_response = '0;
        #1;
        check_eq("t5_empty", 64'(empty), 64'd1);
        check_eq("t5_cmd_none", 64'(proc2mem_command), 64'(CMD_NONE));

        // Pop and allocate together; a match on the popping head allocates anew
        evict(32'hB00, 64'h11);
        tick();
        evict(32'hC00, 64'h22);
        mem2proc_response = 4'd1;
        #1;
        check_eq("t6_head_b", 64'(proc2mem_addr), 64'hB00);
        tick();
        evict(32'hC04, 64'h33);
        #1;
        check_eq("t6_count_pa", 64'(count), 64'd1);
        check_eq("t6_head_c_data", proc2mem_data, 64'h22);
        tick();
        evict_en = 1'b0;
        #1;
        check_eq("t6_count_realloc", 64'(count), 64'd1);
        check_eq("t6_realloc_addr", 64'(proc2mem_addr), 64'hC00);
        check_eq("t6_realloc_data", proc2mem_data, 64'h33);
        tick();
        mem2proc_response = '0;
        #1;
        check_eq("t6_empty", 64'(empty), 64'd1);

        // Full with a same-cycle pop still drops the new line
        bus_busy = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            evict(32'(i * 32'h100), 64'(i * 16));
            tick();
        end
        evict_en = 1'b0;
        bus_busy = 1'b0;
        tick();
        evict(32'hD00, 64'hDD);
        mem2proc_response = 4'd1;
        #1;
        check_eq("t7_head_addr", 64'(proc2mem_addr), 64'h100);
        check_eq("t7_full", 64'(full), 64'd1);
        tick();
        evict_en = 1'b0;
        #1;
        check_eq("t7_count3", 64'(count), 64'd3);
        lookup_en   = 1'b1;
        lookup_addr = 32'hD00;
        #1;
        check_eq("t7_drop_miss", 64'(lookup_hit), 64'd0);
        lookup_addr = 32'h304;
        tick();
        #1;
        check_eq("t7_count2", 64'(count), 64'd2);
        check_eq("t7_cmd_store", 64'(proc2mem_command), 64'(CMD_STORE));
        check_eq("t7_head_300", 64'(proc2mem_addr), 64'h300);
        check_eq("t7_hit_pre_rst", 64'(lookup_hit), 64'd1);

        // Asynchronous reset mid-drain
        reset = 1'b1;
        #1;
        check_eq("t8_cmd", 64'(proc2mem_command), 64'(CMD_NONE));
        check_eq("t8_addr", 64'(proc2mem_addr), 64'h0);
        check_eq("t8_data", proc2mem_data, 64'h0);
        check_eq("t8_count", 64'(count), 64'd0);
        check_eq("t8_empty", 64'(empty), 64'd1);
        check_eq("t8_full", 64'(full), 64'd0);
        check_eq("t8_hit", 64'(lookup_hit), 64'd0);
        check_eq("t8_lookup_data", lookup_data, 64'h0);
        check_eq("t8_overflow", 64'(overflow), 64'd0);
        check_eq("t8_state", 64'(state_dbg), 64'(ST_IDLE));
        tick();
        reset     = 1'b0;
        lookup_en = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #1;
            check_eq("t8_no_store_after", 64'(proc2mem_command), 64'(CMD_NONE));
            tick();
        end
        mem2proc_response = '0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
